// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   - rx_state_e : receiver FSM states. The encodings are gray-coded along the
//                  normal frame path IDLE -> START -> DATA -> PARITY -> STOP.
//   - PAR_EVEN / PAR_ODD : meaning of the PAR_TYP input.
//   - PRESCALE_8/16/32   : the supported oversampling ratios.
//   - majority3()        : 2-of-3 vote used on the mid-bit samples.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [2:0] IDLE_ENC   = 3'b000;
    localparam logic [2:0] START_ENC  = 3'b001;
    localparam logic [2:0] DATA_ENC   = 3'b011;
    localparam logic [2:0] PARITY_ENC = 3'b010;
    localparam logic [2:0] STOP_ENC   = 3'b110;

    typedef enum logic [2:0] {
        IDLE   = IDLE_ENC,
        START  = START_ENC,
        DATA   = DATA_ENC,
        PARITY = PARITY_ENC,
        STOP   = STOP_ENC
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[1] & s[2]) | (s[0] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_fsm_core_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm_core_if
// Bundles the receiver's serial input, frame configuration and result outputs.
//   RX_IN      : serial line, idle high, already synchronized to CLK
//   Prescale   : clocks per bit (8, 16 or 32)
//   PAR_EN     : 1 = parity bit present
//   PAR_TYP    : 0 = even, 1 = odd
//   P_DATA     : last good received byte
//   Data_Valid : 1-cycle pulse, P_DATA updated
//   par_err    : 1-cycle pulse, parity mismatch
//   stp_err    : 1-cycle pulse, stop bit sampled low
// master drives the line and configuration; slave is the receiver.
// -----------------------------------------------------------------------------
interface uart_rx_fsm_core_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      par_err;
    logic                      stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_fsm_core_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit timing for the receiver: counts edges within a bit, captures RX_IN
// three times around mid-bit and majority-votes the result.
//   CLK, RST  : clock, asynchronous active-low reset
//   rx_in     : synchronized serial line
//   start     : start detect, restarts the edge counter
//   run       : receiver is inside a frame
//   prescale  : clocks per bit, latched by the FSM at start detect
//   bit_val   : voted bit value, valid from edge_cnt = prescale/2+2
//   bit_mid   : edge_cnt = prescale/2+2 (first cycle bit_val is valid)
//   bit_end   : edge_cnt = prescale-1 (last cycle of the bit)
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      rx_in,
    input  logic                      start,
    input  logic                      run,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_val,
    output logic                      bit_mid,
    output logic                      bit_end
);

    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] TWO = PRESCALE_WIDTH'(2);

    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] half;
    logic [PRESCALE_WIDTH-1:0] last;
    logic [2:0]                samples;
    logic                      capture;

    assign half    = prescale >> 1;
    assign last    = prescale - ONE;
    assign capture = run && ((edge_cnt == half - ONE) ||
                             (edge_cnt == half)       ||
                             (edge_cnt == half + ONE));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
        end else if (start) begin
            edge_cnt <= '0;
        end else if (run) begin
            edge_cnt <= (edge_cnt == last) ? '0 : edge_cnt + ONE;
        end else begin
            edge_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samples <= '0;
        end else if (capture) begin
            samples <= {samples[1:0], rx_in};
        end
    end

    // Samples hold from the third capture until the next bit's first capture,
    // so the vote is stable over bit_mid..bit_end.
    assign bit_val = majority3(samples);
    assign bit_mid = run && (edge_cnt == half + TWO);
    assign bit_end = run && (edge_cnt == last);

endmodule

// File: rtl/uart_rx_fsm_core.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm_core
// UART receiver: start-bit detection with glitch rejection, LSB-first
// deserialization, optional parity check and stop-bit check.
//   CLK    : system clock
//   RST    : asynchronous active-low reset
//   rx_if  : slave side of uart_rx_fsm_core_if (RX_IN, Prescale, PAR_EN,
//            PAR_TYP in; P_DATA, Data_Valid, par_err, stp_err out)
// Frame configuration is latched at start detect; all outputs are registered.
// A frame completes on the edge ending the stop bit, N*Prescale clocks after
// start detect, N = 1 + DATA_WIDTH + PAR_EN + 1.
// -----------------------------------------------------------------------------
module uart_rx_fsm_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic              CLK,
    input  logic              RST,
    uart_rx_fsm_core_if.slave rx_if
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 3);

    rx_state_e                 state_q;
    rx_state_e                 state_d;

    logic [CNT_W-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic                      par_fail_q;

    logic [DATA_WIDTH-1:0]     p_data_q;
    logic                      data_valid_q;
    logic                      par_err_q;
    logic                      stp_err_q;

    logic                      bit_val;
    logic                      bit_mid;
    logic                      bit_end;

    logic                      start_det;
    logic                      shift_en;
    logic                      par_chk;
    logic                      frame_done;
    logic                      stp_fail;
    logic                      par_expected;

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .CLK      (CLK),
        .RST      (RST),
        .rx_in    (rx_if.RX_IN),
        .start    (start_det),
        .run      (state_q != IDLE),
        .prescale (prescale_q),
        .bit_val  (bit_val),
        .bit_mid  (bit_mid),
        .bit_end  (bit_end)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        par_chk    = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_if.RX_IN) begin
                    start_det = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                // A start bit that votes high at mid-bit was a glitch.
                if (bit_mid && bit_val) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    // bit_cnt is the frame bit index: data occupies 1..DATA_WIDTH.
                    if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_chk = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    assign par_expected = (^shift_q) ^ (par_typ_q == PAR_ODD);
    assign stp_fail     = ~bit_val;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt    <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_fail_q <= 1'b0;
        end else if (start_det) begin
            bit_cnt    <= '0;
            prescale_q <= rx_if.Prescale;
            par_en_q   <= rx_if.PAR_EN;
            par_typ_q  <= rx_if.PAR_TYP;
            par_fail_q <= 1'b0;
        end else begin
            if (bit_end) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (par_chk) begin
                par_fail_q <= (bit_val != par_expected);
            end
        end
    end

    // The shift register is plain flops, so it shares the async reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q <= '0;
        end else if (shift_en) begin
            shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            if (frame_done) begin
                par_err_q <= par_fail_q;
                stp_err_q <= stp_fail;
                if (!par_fail_q && !stp_fail) begin
                    data_valid_q <= 1'b1;
                    p_data_q     <= shift_q;
                end
            end
        end
    end

    assign rx_if.P_DATA     = p_data_q;
    assign rx_if.Data_Valid = data_valid_q;
    assign rx_if.par_err    = par_err_q;
    assign rx_if.stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_fsm_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm_core
// Drives UART frames onto RX_IN and compares every output pulse (cycle, flags,
// data) against a frame-level model: a frame whose start bit is first seen on
// edge s is detected on max(s, first edge the receiver is free), and completes
// N*Prescale edges later with flags derived from the injected faults.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm_core;
    import uart_pkg::*;

    typedef struct {
        int unsigned cyc;
        logic        dv;
        logic        pe;
        logic        se;
        logic [7:0]  data;
    } ev_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    ev_t         exp_q[$];
    ev_t         act_q[$];
    int unsigned rx_free;
    logic [7:0]  last_good;

    uart_rx_fsm_core_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) rx_if ();

    uart_rx_fsm_core #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .rx_if (rx_if)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Record every output pulse with the edge number that produced it.
    always @(negedge CLK) begin
        ev_t a;
        if (rx_if.Data_Valid || rx_if.par_err || rx_if.stp_err) begin
            a.cyc  = cyc;
            a.dv   = rx_if.Data_Valid;
            a.pe   = rx_if.par_err;
            a.se   = rx_if.stp_err;
            a.data = rx_if.P_DATA;
            act_q.push_back(a);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Value set in iteration t is seen on the (t+1)-th following edge; a spike
    // inverts only the middle of the three mid-bit samples.
    task automatic drive_bit(input logic v, input int p, input bit spike);
        for (int t = 0; t < p; t++) begin
            rx_if.RX_IN = (spike && t == p / 2 + 1) ? ~v : v;
            tick();
        end
    endtask

    function automatic int pick_prescale();
        int r;
        r = $urandom_range(0, 2);
        return (r == 0) ? PRESCALE_8 : (r == 1) ? PRESCALE_16 : PRESCALE_32;
    endfunction

    task automatic send_frame(input logic [7:0] data, input int p, input bit pe,
                              input bit pt, input bit bad_par, input bit bad_stop,
                              input int spike_bit, input bit garble);
        logic        bits [0:10];
        int          n;
        int unsigned s;
        int unsigned detect;
        ev_t         e;
        rx_if.Prescale = 6'(p);
        rx_if.PAR_EN   = pe;
        rx_if.PAR_TYP  = pt;
        n      = 10 + (pe ? 1 : 0);
        s      = cyc + 1;
        detect = (s > rx_free) ? s : rx_free;
        e.cyc  = detect + n * p;
        e.pe   = pe && bad_par;
        e.se   = bad_stop;
        e.dv   = !e.pe && !e.se;
        if (e.dv) last_good = data;
        e.data = last_good;
        exp_q.push_back(e);
        rx_free = e.cyc + 1;

        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i + 1] = data[i];
        bits[9]  = (^data) ^ pt ^ bad_par;
        bits[n - 1] = !bad_stop;
        for (int k = 0; k < n; k++) begin
            if (garble && k == 1) begin
                rx_if.Prescale = 6'(pick_prescale());
                rx_if.PAR_EN   = 1'($urandom_range(0, 1));
                rx_if.PAR_TYP  = 1'($urandom_range(0, 1));
            end
            drive_bit(bits[k], p, spike_bit == k);
        end
        rx_if.RX_IN = 1'b1;
    endtask

    task automatic verify(input string tag);
        ev_t e;
        ev_t a;
        check({tag, "_events"}, act_q.size(), exp_q.size());
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            check({tag, "_cyc"},  a.cyc,  e.cyc);
            check({tag, "_dv"},   a.dv,   e.dv);
            check({tag, "_pe"},   a.pe,   e.pe);
            check({tag, "_se"},   a.se,   e.se);
            check({tag, "_data"}, a.data, e.data);
        end
        exp_q.delete();
        act_q.delete();
        check({tag, "_p_data_hold"}, rx_if.P_DATA, last_good);
    endtask

    initial begin
        rx_if.RX_IN    = 1'b1;
        rx_if.Prescale = 6'd8;
        rx_if.PAR_EN   = 1'b0;
        rx_if.PAR_TYP  = 1'b0;
        last_good      = 8'h00;
        repeat (3) tick();
        check("rst_p_data", rx_if.P_DATA, 0);
        check("rst_dv",     rx_if.Data_Valid, 0);
        check("rst_pe",     rx_if.par_err, 0);
        check("rst_se",     rx_if.stp_err, 0);
        RST = 1'b1;
        rx_free = cyc + 1;
        repeat (4) tick();

        // 1: good frame, even parity, pulse 88 clocks after detect.
        send_frame(8'hA5, 8, 1'b1, PAR_EVEN, 1'b0, 1'b0, -1, 1'b0);
        repeat (4) tick();
        verify("t1");

        // 2: same frame with the parity bit flipped.
        send_frame(8'hA5, 8, 1'b1, PAR_EVEN, 1'b1, 1'b0, -1, 1'b0);
        repeat (4) tick();
        verify("t2");

        // 3: no parity, stop bit low, pulse 160 clocks after detect.
        send_frame(8'h3C, 16, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 1'b0);
        repeat (4) tick();
        verify("t3");

        // 4: 3-clock low glitch is rejected, then a frame with a mid-bit spike.
        rx_if.Prescale = 6'd8;
        rx_if.RX_IN = 1'b0;
        repeat (3) tick();
        rx_if.RX_IN = 1'b1;
        repeat (20) tick();
        rx_free = cyc + 1;
        verify("t4_glitch");
        send_frame(8'h55, 8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 3, 1'b0);
        repeat (4) tick();
        verify("t4");

        // 5: back-to-back frames; the second start is seen one edge after the
        // first frame completes, so its pulse lands 321 edges after the first.
        send_frame(8'h01, 32, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, 1'b0);
        send_frame(8'hFF, 32, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, 1'b0);
        repeat (8) tick();
        verify("t5");

        // 6: reset in the middle of the data bits clears the outputs at once.
        rx_if.Prescale = 6'd8;
        rx_if.PAR_EN   = 1'b1;
        rx_if.PAR_TYP  = PAR_ODD;
        drive_bit(1'b0, 8, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 8, 1'b0);
        RST = 1'b0;
        #1;
        check("t6_rst_p_data", rx_if.P_DATA, 0);
        check("t6_rst_dv",     rx_if.Data_Valid, 0);
        check("t6_rst_pe",     rx_if.par_err, 0);
        check("t6_rst_se",     rx_if.stp_err, 0);
        rx_if.RX_IN = 1'b1;
        repeat (3) tick();
        RST = 1'b1;
        last_good = 8'h00;
        rx_free = cyc + 1;
        repeat (2) tick();
        send_frame(8'h81, 8, 1'b1, PAR_ODD, 1'b0, 1'b0, -1, 1'b0);
        repeat (4) tick();
        verify("t6");

        // Random frames with faults, spikes, mid-frame config changes, gaps >= 1.
        for (int f = 0; f < 24; f++) begin
            logic [7:0] d;
            int         p;
            bit         pe;
            bit         pt;
            bit         bp;
            bit         bs;
            int         sp;
            d  = 8'($urandom);
            p  = pick_prescale();
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            bp = pe && ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 4) == 0);
            sp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
            send_frame(d, p, pe, pt, bp, bs, sp, 1'b1);
            repeat ($urandom_range(1, 3)) tick();
        end
        repeat (10) tick();
        verify("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
